// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART RX state machine and the CPU data port, with sticky overflow
// and hysteretic RTS; define UART_RX_FIFO_RTS_EN to build the RTS logic (otherwise rts is tied low).
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int RTS_HI     = 12,
    parameter int RTS_LO     = 4
) (
    input  logic                  clk28,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  rd_req,
    output logic [7:0]            dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic                  rts
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    if (!((RTS_LO < RTS_HI) && (RTS_HI < DEPTH))) begin : g_bad_rts_cfg
        $error("uart_rx_fifo: RTS thresholds must satisfy RTS_LO < RTS_HI < depth");
    end

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic          rd_req_d;
    logic          pop_edge;
    logic          pop;
    logic          push;
    logic          drop;

    // The extra pointer bit lets a full FIFO (level == DEPTH) be told apart from an empty one.
    assign level      = wr_ptr - rd_ptr;
    assign empty      = (level == '0);
    assign full       = (level == PW'(DEPTH));

    assign pop_edge   = rd_req & ~rd_req_d;
    assign pop        = pop_edge & ~empty;
    assign push       = rx_valid & (~full | pop);
    assign drop       = rx_valid & full & ~pop;

    assign wr_ptr_nxt = wr_ptr + PW'(push);
    assign rd_ptr_nxt = rd_ptr + PW'(pop);

    always_ff @(posedge clk28) begin
        if (push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_req_d <= 1'b0;
            dout     <= 8'h00;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            rd_req_d <= rd_req;
            // A read of an empty FIFO still consumes the read cycle and returns zero.
            if (pop_edge) begin
                dout <= pop ? mem[rd_ptr[DEPTH_LOG2-1:0]] : 8'h00;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_RTS_EN
    localparam logic [PW-1:0] RTS_HI_L = PW'(RTS_HI);
    localparam logic [PW-1:0] RTS_LO_L = PW'(RTS_LO);

    logic [PW-1:0] level_nxt;

    assign level_nxt = wr_ptr_nxt - rd_ptr_nxt;

    // Thresholds look at the level this edge produces, so rts reacts in the same cycle as the fill.
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            rts <= 1'b1;
        end else if (level_nxt >= RTS_HI_L) begin
            rts <= 1'b1;
        end else if (level_nxt <= RTS_LO_L) begin
            rts <= 1'b0;
        end
    end
`else
    assign rts = 1'b0;
`endif

endmodule
